// File: rtl/seg7_pkg.sv
// Shared seven-segment display definitions: digit count, blanking constants and
// the active-low hex glyph table (bit order {g,f,e,d,c,b,a}).
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        logic [6:0] glyph;
        glyph = SEG_OFF;
        case (nibble)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            default: glyph = SEG_F;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder, shared by any
// display driver in the design.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    always_comb begin
        segments = hex_glyph(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed hex display driver with frame-coherent snapshot,
// anti-ghosting guard cycles and optional leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
)
(
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic        en,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PRE_GUARD = PW'(GUARD);
    localparam digit_idx_t    LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

    logic [PW-1:0] prescaler;
    digit_idx_t    digit_idx;
    logic [15:0]   snap_value;
    logic [3:0]    snap_dp;
    logic          tick;
    logic [3:0]    nib;
    logic [6:0]    glyph;
    logic          lz_blank;
    logic          lit;
    logic [3:0]    an_sel;

    assign tick = (prescaler == PRE_LAST);

    // Prescaler and scan counter free-run so the scan phase survives en toggles.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            digit_idx <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                digit_idx <= digit_idx + 1'b1;
            end
        end
    end

    // Capture on the last tick of a frame so all four digits show one value.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            snap_value <= 16'h0000;
            snap_dp    <= 4'h0;
        end else if (tick && digit_idx == LAST_DIGIT) begin
            snap_value <= value;
            snap_dp    <= dp_mask;
        end
    end

    assign nib = snap_value[{digit_idx, 2'b00} +: 4];

    hex_to_seg7 u_decode (
        .nibble   (nib),
        .segments (glyph)
    );

    always_comb begin
        lz_blank = 1'b0;
        case (digit_idx)
            2'd1:    lz_blank = blank_lz && (snap_value[15:4]  == 12'h000);
            2'd2:    lz_blank = blank_lz && (snap_value[15:8]  == 8'h00);
            2'd3:    lz_blank = blank_lz && (snap_value[15:12] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
    end

    always_comb begin
        an_sel = AN_OFF;
        case (digit_idx)
            2'd0:    an_sel = 4'b1110;
            2'd1:    an_sel = 4'b1101;
            2'd2:    an_sel = 4'b1011;
            default: an_sel = 4'b0111;
        endcase
    end

    assign lit = en && (prescaler >= PRE_GUARD) && !lz_blank;

    // Registered pins; reset darkens the display without waiting for a clock.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (lit) begin
            an  <= an_sel;
            seg <= glyph;
            dp  <= ~snap_dp[digit_idx];
        end else begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end
    end

endmodule
